// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the radix-2 DIT FFT controller.
// Holds the sequencer state enum, N_LOG2-derived width helpers and the
// bit-reverse function also used by the output reorder logic.
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fft_state_e;

  localparam int N_LOG2_MAX = 12;
  localparam int N_LOG2_DEF = 8;
  localparam int ADDR_W_DEF = N_LOG2_DEF;
  localparam int TW_W_DEF   = N_LOG2_DEF - 1;
  localparam int STAGE_W_DEF = $clog2(N_LOG2_DEF);

  // data-RAM address width
  function automatic int addr_w(input int n_log2);
    return n_log2;
  endfunction

  // twiddle-ROM index width (N/2 entries)
  function automatic int tw_w(input int n_log2);
    return n_log2 - 1;
  endfunction

  // stage counter width
  function automatic int stage_w(input int n_log2);
    return $clog2(n_log2);
  endfunction

  // reverse the low w bits of v; bits at and above w are returned as zero
  function automatic logic [N_LOG2_MAX-1:0] bit_rev(input logic [N_LOG2_MAX-1:0] v,
                                                    input int w);
    logic [N_LOG2_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < N_LOG2_MAX; i++) begin
      if (i < w) begin
        r[i] = v[w-1-i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_dly.sv
// fft_addr_dly: PIPE-deep shift register carrying {rd_en, rd_addr_a, rd_addr_b}
// so that the butterfly enable and write-back controls line up with the
// datapath. The enable is the MSB of the carried word.
module fft_addr_dly #(
  parameter int PIPE = 2,
  parameter int W    = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         tap1_en,
  output logic [W-1:0] tapn
);

  logic [W-1:0] sr_r [PIPE];

  // shift the read controls one slot per cycle; reset discards in-flight writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) begin
        sr_r[i] <= '0;
      end
    end else begin
      sr_r[0] <= din;
      for (int i = 1; i < PIPE; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

  assign tap1_en = sr_r[0][W-1];
  assign tapn    = sr_r[PIPE-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: stage/butterfly sequencer for the in-place radix-2 DIT FFT.
// Optional feature macro: FFT_CTRL_BITREV_EN adds a LOAD state that writes
// incoming samples to bit-reversed addresses before the first stage.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = 8,
  parameter int PIPE   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
`ifdef FFT_CTRL_BITREV_EN
  input  logic                          ld_valid,
  output logic                          ld_we,
  output logic [addr_w(N_LOG2)-1:0]     ld_addr,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [addr_w(N_LOG2)-1:0]     rd_addr_a,
  output logic [addr_w(N_LOG2)-1:0]     rd_addr_b,
  output logic [tw_w(N_LOG2)-1:0]       tw_addr,
  output logic                          bf_en,
  output logic                          wr_en,
  output logic [addr_w(N_LOG2)-1:0]     wr_addr_a,
  output logic [addr_w(N_LOG2)-1:0]     wr_addr_b,
  output logic [stage_w(N_LOG2)-1:0]    stage
);

  localparam int AW  = addr_w(N_LOG2);
  localparam int KW  = tw_w(N_LOG2);
  localparam int SW  = stage_w(N_LOG2);
  localparam int FW  = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam int DW  = 1 + 2 * AW;

  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  localparam logic [FW-1:0] F_LAST = FW'(PIPE - 1);

`ifdef FFT_CTRL_BITREV_EN
  localparam fft_state_e START_TGT = ST_LOAD;
`else
  localparam fft_state_e START_TGT = ST_RUN;
`endif

  fft_state_e     state_r, state_nxt_s;
  logic [KW-1:0]  k_r, k_nxt_s;
  logic [SW-1:0]  stage_r, stage_nxt_s;
  logic [FW-1:0]  flush_r, flush_nxt_s;

  logic [KW-1:0]  span_k_s, pos_s, grp_s, tw_s;
  logic [SW-1:0]  tw_sh_s;
  logic [AW-1:0]  span_a_s, addr_a_s, addr_b_s;
  logic           run_nxt_s;

  logic           busy_r, done_r, rd_en_r;
  logic [AW-1:0]  rd_addr_a_r, rd_addr_b_r;
  logic [KW-1:0]  tw_addr_r;
  logic [DW-1:0]  dly_tapn_s;
  logic           dly_tap1_s;

`ifdef FFT_CTRL_BITREV_EN
  logic [AW-1:0]         ld_cnt_r, ld_cnt_nxt_s;
  logic [AW-1:0]         ld_addr_r;
  logic [N_LOG2_MAX-1:0] ld_ext_s, ld_rev_s;
  logic                  ld_acc_s, ld_last_s;
`endif

`ifdef FFT_CTRL_BITREV_EN
  // load counter: one step per accepted sample, bit-reversed for the write address
  always_comb begin
    ld_acc_s     = (state_r == ST_LOAD) && ld_valid;
    ld_last_s    = ld_acc_s && (ld_cnt_r == {AW{1'b1}});
    ld_cnt_nxt_s = ld_cnt_r;
    if (state_r == ST_IDLE) begin
      ld_cnt_nxt_s = '0;
    end else if (ld_acc_s) begin
      ld_cnt_nxt_s = ld_cnt_r + AW'(1'b1);
    end else begin
      ld_cnt_nxt_s = ld_cnt_r;
    end
    ld_ext_s = '0;
    ld_ext_s[AW-1:0] = ld_cnt_nxt_s;
    ld_rev_s = bit_rev(ld_ext_s, N_LOG2);
  end

  // load counter and bit-reversed address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_r  <= '0;
      ld_addr_r <= '0;
    end else begin
      ld_cnt_r  <= ld_cnt_nxt_s;
      ld_addr_r <= ld_rev_s[AW-1:0];
    end
  end

  assign ld_we   = ld_acc_s;
  assign ld_addr = ld_addr_r;
`endif

  // next-state logic for the stage / butterfly / flush counters
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    stage_nxt_s = stage_r;
    flush_nxt_s = flush_r;
    case (state_r)
      ST_IDLE: begin
        k_nxt_s     = '0;
        stage_nxt_s = '0;
        flush_nxt_s = '0;
        if (start) begin
          state_nxt_s = START_TGT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
`ifdef FFT_CTRL_BITREV_EN
        if (ld_last_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_RUN: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ST_FLUSH;
          k_nxt_s     = '0;
          flush_nxt_s = '0;
        end else begin
          k_nxt_s = k_r + KW'(1'b1);
        end
      end
      ST_FLUSH: begin
        if (flush_r == F_LAST) begin
          flush_nxt_s = '0;
          if (stage_r == S_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            stage_nxt_s = stage_r + SW'(1'b1);
            state_nxt_s = ST_RUN;
          end
        end else begin
          flush_nxt_s = flush_r + FW'(1'b1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        k_nxt_s     = '0;
        stage_nxt_s = '0;
        flush_nxt_s = '0;
      end
    endcase
  end

  // butterfly address mapping for the butterfly that will be read next cycle
  always_comb begin
    run_nxt_s = (state_nxt_s == ST_RUN);
    // span overflows to 0 in the last stage, which makes the mask all ones
    span_k_s  = KW'(1'b1) << stage_nxt_s;
    pos_s     = k_nxt_s & (span_k_s - KW'(1'b1));
    grp_s     = k_nxt_s >> stage_nxt_s;
    span_a_s  = AW'(1'b1) << stage_nxt_s;
    tw_sh_s   = S_LAST - stage_nxt_s;
    if (run_nxt_s) begin
      addr_a_s = ((AW'(grp_s) << stage_nxt_s) << 1) | AW'(pos_s);
      addr_b_s = addr_a_s + span_a_s;
      tw_s     = pos_s << tw_sh_s;
    end else begin
      addr_a_s = '0;
      addr_b_s = '0;
      tw_s     = '0;
    end
  end

  // state, counters and registered read-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      k_r         <= '0;
      stage_r     <= '0;
      flush_r     <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_a_r <= '0;
      rd_addr_b_r <= '0;
      tw_addr_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      k_r         <= k_nxt_s;
      stage_r     <= stage_nxt_s;
      flush_r     <= flush_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= (state_nxt_s == ST_DONE);
      rd_en_r     <= run_nxt_s;
      rd_addr_a_r <= addr_a_s;
      rd_addr_b_r <= addr_b_s;
      tw_addr_r   <= tw_s;
    end
  end

  fft_addr_dly #(
    .PIPE (PIPE),
    .W    (DW)
  ) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     ({rd_en_r, rd_addr_a_r, rd_addr_b_r}),
    .tap1_en (dly_tap1_s),
    .tapn    (dly_tapn_s)
  );

  assign busy      = busy_r;
  assign done      = done_r;
  assign rd_en     = rd_en_r;
  assign rd_addr_a = rd_addr_a_r;
  assign rd_addr_b = rd_addr_b_r;
  assign tw_addr   = tw_addr_r;
  assign stage     = stage_r;
  assign bf_en     = dly_tap1_s;
  assign wr_en     = dly_tapn_s[DW-1];
  assign wr_addr_a = dly_tapn_s[2*AW-1:AW];
  assign wr_addr_b = dly_tapn_s[AW-1:0];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: scoreboard bench for fft_stage_ctrl with N_LOG2=3.
// Two instances (PIPE=2 and PIPE=3); a select steers one of them to the monitor.
module tb_fft_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v = 1'b0;
  logic sel = 1'b0;
  logic start2, start3;

  always #5 clk = ~clk;

  assign start2 = start_v & ~sel;
  assign start3 = start_v & sel;

  logic       busy2, done2, rd_en2, bf_en2, wr_en2;
  logic [2:0] rda2, rdb2, wra2, wrb2;
  logic [1:0] tw2, st2;
  logic       busy3, done3, rd_en3, bf_en3, wr_en3;
  logic [2:0] rda3, rdb3, wra3, wrb3;
  logic [1:0] tw3, st3;

`ifdef FFT_CTRL_BITREV_EN
  logic       ld_v = 1'b0;
  logic       ld_we2, ld_we3, m_ld_we;
  logic [2:0] ld_addr2, ld_addr3, m_ld_addr;
  int ld_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  assign m_ld_we   = sel ? ld_we3 : ld_we2;
  assign m_ld_addr = sel ? ld_addr3 : ld_addr2;
`endif

  fft_stage_ctrl #(.N_LOG2(3), .PIPE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef FFT_CTRL_BITREV_EN
    .ld_valid(ld_v & ~sel), .ld_we(ld_we2), .ld_addr(ld_addr2),
`endif
    .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr_a(rda2), .rd_addr_b(rdb2),
    .tw_addr(tw2), .bf_en(bf_en2), .wr_en(wr_en2), .wr_addr_a(wra2), .wr_addr_b(wrb2),
    .stage(st2)
  );

  fft_stage_ctrl #(.N_LOG2(3), .PIPE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef FFT_CTRL_BITREV_EN
    .ld_valid(ld_v & sel), .ld_we(ld_we3), .ld_addr(ld_addr3),
`endif
    .busy(busy3), .done(done3), .rd_en(rd_en3), .rd_addr_a(rda3), .rd_addr_b(rdb3),
    .tw_addr(tw3), .bf_en(bf_en3), .wr_en(wr_en3), .wr_addr_a(wra3), .wr_addr_b(wrb3),
    .stage(st3)
  );

  logic       m_busy, m_done, m_rd_en, m_bf_en, m_wr_en;
  logic [2:0] m_rda, m_rdb, m_wra, m_wrb;
  logic [1:0] m_tw, m_st;
  assign m_busy  = sel ? busy3  : busy2;
  assign m_done  = sel ? done3  : done2;
  assign m_rd_en = sel ? rd_en3 : rd_en2;
  assign m_bf_en = sel ? bf_en3 : bf_en2;
  assign m_wr_en = sel ? wr_en3 : wr_en2;
  assign m_rda   = sel ? rda3   : rda2;
  assign m_rdb   = sel ? rdb3   : rdb2;
  assign m_wra   = sel ? wra3   : wra2;
  assign m_wrb   = sel ? wrb3   : wrb2;
  assign m_tw    = sel ? tw3    : tw2;
  assign m_st    = sel ? st3    : st2;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } exp_t;

  exp_t rd_q[$];
  exp_t wr_q[$];
  int   bf_q[$];
  int   done_q[$];
  exp_t mon_e;

  // hand-computed butterfly table for N=8: stage 0, stage 1, stage 2
  int tab_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int tab_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  int busy_cnt = 0;
  int done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pop the scoreboard whenever the selected DUT presents an event
  always @(negedge clk) begin
    if (m_busy && !m_done) busy_cnt++;
    if (m_rd_en) begin
      rd_seen++;
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        mon_e = rd_q.pop_front();
        chk("rd_cycle", cyc, mon_e.cyc);
        chk("rd_addr_a", int'(m_rda), mon_e.a);
        chk("rd_addr_b", int'(m_rdb), mon_e.b);
        chk("tw_addr", int'(m_tw), mon_e.tw);
        chk("stage", int'(m_st), mon_e.st);
      end
    end
    if (m_bf_en) begin
      if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
      else chk("bf_cycle", cyc, bf_q.pop_front());
    end
    if (m_wr_en) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        mon_e = wr_q.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_addr_a", int'(m_wra), mon_e.a);
        chk("wr_addr_b", int'(m_wrb), mon_e.b);
      end
    end
    if (m_done) begin
      done_seen = 1;
      chk("done_busy", int'(m_busy), 1);
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  // issue a start and push the whole transform's expected events
  task automatic launch(input int p);
    int   t0;
    int   c;
    exp_t e;
    @(negedge clk);
    start_v = 1'b1;
    @(posedge clk);
    #1;
    start_v = 1'b0;
`ifdef FFT_CTRL_BITREV_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld_v = 1'b1;
      #1;
      chk("ld_we", int'(m_ld_we), 1);
      chk("ld_addr", int'(m_ld_addr), ld_tab[i]);
      @(posedge clk);
      #1;
      ld_v = 1'b0;
    end
`endif
    t0 = cyc;
    rd_seen = 0;
    wr_seen = 0;
    busy_cnt = 0;
    done_seen = 0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        c = t0 + s * (4 + p) + k;
        e.cyc = c;
        e.a = tab_a[s*4+k];
        e.b = tab_b[s*4+k];
        e.tw = tab_tw[s*4+k];
        e.st = s;
        rd_q.push_back(e);
        bf_q.push_back(c + 1);
        e.cyc = c + p;
        wr_q.push_back(e);
      end
    end
    done_q.push_back(t0 + 3 * (4 + p));
  endtask

  // wait (bounded) for done, then check totals and an empty scoreboard
  task automatic finish_xfer(input int p);
    int n;
    n = 0;
    while (done_seen == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_seen, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rd_count", rd_seen, 12);
    chk("wr_count", wr_seen, 12);
    chk("busy_cycles", busy_cnt, 3 * (4 + p));
    chk("queues_empty", rd_q.size() + wr_q.size() + bf_q.size() + done_q.size(), 0);
    chk("idle_busy", int'(m_busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(m_busy), 0);
    chk({tag, "_done"}, int'(m_done), 0);
    chk({tag, "_rd_en"}, int'(m_rd_en), 0);
    chk({tag, "_bf_en"}, int'(m_bf_en), 0);
    chk({tag, "_wr_en"}, int'(m_wr_en), 0);
    chk({tag, "_addrs"}, int'(m_rda) + int'(m_rdb) + int'(m_wra) + int'(m_wrb) + int'(m_tw), 0);
    chk({tag, "_stage"}, int'(m_st), 0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    chk("reset_busy3", int'(busy3), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // plain transform, PIPE=2
    launch(2);
    finish_xfer(2);

    // second start mid-stage 1 must be ignored
    launch(2);
    repeat (8) @(negedge clk);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    finish_xfer(2);

    // pipeline alignment with PIPE=3
    sel = 1'b1;
    launch(3);
    finish_xfer(3);
    @(negedge clk);
    sel = 1'b0;

    // reset during stage 1, then a full transform
    launch(2);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    rd_q.delete();
    wr_q.delete();
    bf_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    launch(2);
    finish_xfer(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencer for the in-place radix-2 DIT FFT core. It steps through every stage and butterfly, and drives the data-RAM read and write addresses, the twiddle-ROM address and the butterfly adder enable. Write-back addresses are delayed to match the datapath pipeline. It sits between the top-level start/done handshake and the butterfly datapath: dual-port data RAM, twiddle multiplier and add/subtract butterfly.

## Interface
Parameters:
- N_LOG2, default 8: log2 of FFT length N. Legal range 2..12.
- PIPE, default 2: cycles from rd_en to the matching wr_en (RAM read + twiddle multiply + butterfly). Minimum 1.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request a transform. Sampled only in IDLE.
- busy, output, 1: high from the cycle after start is accepted through the DONE cycle.
- done, output, 1: one-cycle pulse once the final butterfly has been written back.
- rd_en, output, 1: read both butterfly operands this cycle.
- rd_addr_a, output, N_LOG2: upper-leg read address.
- rd_addr_b, output, N_LOG2: lower-leg read address.
- tw_addr, output, N_LOG2-1: twiddle-ROM index for the current butterfly.
- bf_en, output, 1: butterfly adder enable. Equals rd_en delayed 1 cycle.
- wr_en, output, 1: write both results. Equals rd_en delayed PIPE cycles.
- wr_addr_a, output, N_LOG2: rd_addr_a delayed PIPE cycles.
- wr_addr_b, output, N_LOG2: rd_addr_b delayed PIPE cycles.
- stage, output, clog2(N_LOG2): current stage, for scaling control.

## Operation
- State machine: IDLE, (LOAD), RUN, FLUSH, DONE.
- IDLE:
  - start=1 goes to RUN, or to LOAD with FFT_CTRL_BITREV_EN.
  - Clears stage and k.
- RUN:
  - rd_en=1 every cycle. k counts 0..N/2-1.
  - On k=N/2-1, go to FLUSH.
- FLUSH:
  - rd_en=0 for exactly PIPE cycles, so the stage's writes drain before the next stage reads.
  - Then stage+1 and RUN; after the last stage (stage=N_LOG2-1), go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Address mapping, per stage s and butterfly k:
  - span = 1<<s, pos = k & (span-1), grp = k >> s.
  - rd_addr_a = (grp << (s+1)) | pos.
  - rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (N_LOG2-1-s).
  - All arithmetic is unsigned with no wrap: a+span < N always.
- start while busy: ignored; no queuing.
- Reset mid-transform:
  - All outputs 0, delay lines cleared, state IDLE.
  - Writes still in flight are discarded.

## Timing
- Reset values: busy, done, rd_en, bf_en, wr_en, all addresses, stage = 0.
- start sampled high in IDLE at edge T0: RUN begins in the next cycle, with rd_en=1, stage 0, k=0.
- Each stage takes N/2 RUN cycles + PIPE FLUSH cycles.
- busy duration (without macro): N_LOG2*(N/2+PIPE) cycles, plus the 1 DONE cycle.
- The last wr_en falls in the final FLUSH cycle; done is asserted in the following cycle.
- Stage boundary: the first read of stage s+1 occurs one cycle after the last write of stage s. The RAM must be read-after-write safe across edges.
- start and done may be high in the same cycle only if done is already in DONE; start there is ignored.

## Configuration
- FFT_CTRL_BITREV_EN defined:
  - Adds ports ld_valid (input, 1), ld_we (output, 1) and ld_addr (output, N_LOG2).
  - Adds state LOAD: each ld_valid cycle gives ld_we=1 and ld_addr = bit-reverse(load counter).
  - After N accepted samples, go to RUN.
  - busy is high during LOAD.
- Not defined:
  - No LOAD state and no extra ports.
  - Data is preloaded in bit-reversed order by the host.

## Structure
- Shared package fft_pkg holds:
  - the state enum;
  - the N_LOG2-derived width localparams (address, twiddle and stage widths);
  - a bit-reverse function, shared with the output reorder logic.
- Sub-module fft_addr_dly: a PIPE-deep shift register carrying {rd_en, rd_addr_a, rd_addr_b}. Taps:
  - tap 1 gives bf_en;
  - tap PIPE gives wr_en and the write addresses.
- The address mapping is combinational logic inside fft_stage_ctrl.

## Test plan
- Setup for all tests: N_LOG2=3 and PIPE=2 unless stated.
- Cycle count: start pulse → busy high for 18 cycles, done pulses in the 19th cycle after start, with exactly 12 rd_en cycles and 12 wr_en cycles.
- Address check:
  - stage 1, k=1 → rd_addr_a=1, rd_addr_b=3, tw_addr=2;
  - stage 2, k=3 → rd_addr_a=3, rd_addr_b=7, tw_addr=3.
- Pipeline alignment: with PIPE=3, wr_addr_a/b equal rd_addr_a/b from 3 cycles earlier, and no rd_en is high while a previous-stage wr_en is pending.
- start during busy: a second start pulse mid-stage 1 is ignored and the total count is unchanged.
- Reset mid-transform: rst_n low during stage 1 → all outputs 0 immediately; a later start runs a full 18-cycle transform.
- FFT_CTRL_BITREV_EN: 8 ld_valid pulses produce ld_addr sequence 0,4,2,6,1,5,3,7, then RUN starts.
